// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and the IF/ID pipeline register, and drives the instruction
// cache read port. A small FSM absorbs multi-cycle cache misses and holds
// any branch/jump redirect that arrives mid-miss until the miss completes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PCWrite, if_id_Write     load-use stall controls (0 = hold)
//   branch_taken/_target     ID-resolved branch redirect
//   jump/jump_target         ID-resolved jump redirect (wins over branch)
//   ICACHE_ren/_addr         read request, word address pc[31:2]
//   ICACHE_stall/_rdata      miss indication, zero-latency read data
//   if_id_pc4/_instr/_valid  IF/ID pipeline register
//   fetch_stall              mirrors ICACHE_stall for downstream freeze
//   stall_cycles             saturating count of cache-stall cycles
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        if_id_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic        ICACHE_stall,
  input  logic [31:0] ICACHE_rdata,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_stall,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN,
    MISS,
    MISS_REDIR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] scnt_q, scnt_d;

  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redir    = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    scnt_d  = scnt_q;

    if (ICACHE_stall && (scnt_q != '1)) begin
      scnt_d = scnt_q + 32'd1;
    end

    if (ICACHE_stall) begin
      // PC and IF/ID freeze; only the redirect bookkeeping moves.
      if (redir) begin
        pend_d  = target;
        state_d = MISS_REDIR;
      end else if (state_q == RUN) begin
        state_d = MISS;
      end
    end else begin
      state_d = RUN;
      // A live redirect beats the parked one; a parked redirect discards
      // the data returned for the stale address.
      if (redir || (state_q == MISS_REDIR)) begin
        pc_d    = redir ? target : pend_q;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        if (PCWrite) begin
          pc_d = pc_plus4;
        end
        if (if_id_Write) begin
          instr_d = ICACHE_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      scnt_q  <= scnt_d;
    end
  end

  assign ICACHE_ren   = ~rst;
  assign ICACHE_addr  = pc_q[31:2];
  assign if_id_pc4    = pc4_q;
  assign if_id_instr  = instr_q;
  assign if_id_valid  = valid_q;
  assign fetch_stall  = ICACHE_stall;
  assign stall_cycles = scnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The cache model returns
// {addr,2'b00} ^ 32'hCAFE_0000, so instructions are recognisable by address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite;
  logic        if_id_Write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic        ICACHE_stall;
  logic [31:0] ICACHE_rdata;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_stall;
  logic [31:0] stall_cycles;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  always_comb ICACHE_rdata = {ICACHE_addr, 2'b00} ^ 32'hCAFE_0000;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .if_id_Write  (if_id_Write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .ICACHE_ren   (ICACHE_ren),
    .ICACHE_addr  (ICACHE_addr),
    .ICACHE_stall (ICACHE_stall),
    .ICACHE_rdata (ICACHE_rdata),
    .if_id_pc4    (if_id_pc4),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_stall  (fetch_stall),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] instr, input logic valid);
    chk({tag, ".pc"},    {ICACHE_addr, 2'b00}, pc);
    chk({tag, ".pc4"},   if_id_pc4, pc4);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; PCWrite = 1'b1; if_id_Write = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; ICACHE_stall = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst.ren", {31'd0, ICACHE_ren}, 32'd0);
    chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst.scnt", stall_cycles, 32'd0);
    rst = 1'b0;
    #1;
    chk("run.ren", {31'd0, ICACHE_ren}, 32'd1);

    // 1: free run
    tick(); chk_if("t1a", 32'h4,  32'h4,  32'hCAFE_0000, 1'b1);
    tick(); chk_if("t1b", 32'h8,  32'h8,  32'hCAFE_0004, 1'b1);
    tick(); chk_if("t1c", 32'hC,  32'hC,  32'hCAFE_0008, 1'b1);
    tick(); chk_if("t1d", 32'h10, 32'h10, 32'hCAFE_000C, 1'b1);

    // 2: load-use hold for two cycles at pc=0x10
    PCWrite = 1'b0; if_id_Write = 1'b0;
    tick(); chk_if("t2a", 32'h10, 32'h10, 32'hCAFE_000C, 1'b1);
    tick(); chk_if("t2b", 32'h10, 32'h10, 32'hCAFE_000C, 1'b1);
    PCWrite = 1'b1; if_id_Write = 1'b1;
    tick(); chk_if("t2c", 32'h14, 32'h14, 32'hCAFE_0010, 1'b1);

    // 3: jump beats branch; redirect also overrides a held PCWrite
    branch_taken = 1'b1; branch_target = 32'h100;
    jump = 1'b1; jump_target = 32'h200; PCWrite = 1'b0; if_id_Write = 1'b0;
    tick(); chk_if("t3", 32'h200, 32'h14, 32'h0, 1'b0);
    branch_taken = 1'b0; PCWrite = 1'b1; if_id_Write = 1'b1;

    // Steer to pc=0x20 with a valid instruction in IF/ID
    jump_target = 32'h1C;
    tick(); chk("t4.setup", {ICACHE_addr, 2'b00}, 32'h1C);
    jump = 1'b0;
    tick(); chk_if("t4.pre", 32'h20, 32'h20, 32'hCAFE_001C, 1'b1);

    // 4: five-cycle miss with two redirects; the newest must win
    ICACHE_stall = 1'b1;
    #1; chk("t4.fstall", {31'd0, fetch_stall}, 32'd1);
    tick();
    branch_taken = 1'b1; branch_target = 32'h80;
    tick(); chk_if("t4.hold", 32'h20, 32'h20, 32'hCAFE_001C, 1'b1);
    branch_taken = 1'b0;
    tick();
    jump = 1'b1; jump_target = 32'h40;
    tick();
    jump = 1'b0;
    tick(); chk("t4.scnt", stall_cycles, 32'd5);
    ICACHE_stall = 1'b0;
    tick(); chk_if("t4.post", 32'h40, 32'h20, 32'h0, 1'b0);
    chk("t4.scnt2", stall_cycles, 32'd5);

    // Plain miss completes with a normal fetch update
    ICACHE_stall = 1'b1;
    tick(); chk_if("miss.hold", 32'h40, 32'h20, 32'h0, 1'b0);
    ICACHE_stall = 1'b0;
    tick(); chk_if("miss.done", 32'h44, 32'h44, 32'hCAFE_0040, 1'b1);
    chk("miss.scnt", stall_cycles, 32'd6);

    // 5: reset during MISS_REDIR drops the parked redirect
    ICACHE_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    tick(); chk("t5.scnt", stall_cycles, 32'd7);
    branch_taken = 1'b0; rst = 1'b1;
    tick(); chk_if("t5.rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("t5.scnt0", stall_cycles, 32'd0);
    branch_taken = 1'b1;
    tick(); chk_if("t5.rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("t5.scnt1", stall_cycles, 32'd0);
    branch_taken = 1'b0; rst = 1'b0; ICACHE_stall = 1'b0;
    tick(); chk_if("t5.after", 32'h4, 32'h4, 32'hCAFE_0000, 1'b1);

    // 6: wrap from 0xFFFF_FFFC
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); chk("t6.pc", {ICACHE_addr, 2'b00}, 32'hFFFF_FFFC);
    jump = 1'b0;
    tick(); chk_if("t6.wrap", 32'h0, 32'h0, 32'h3501_FFFC, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Consumes the load-use stall controls PCWrite and if_id_Write from the hazard-detection logic, and the branch/jump redirects resolved in ID.
- Drives the ICACHE read port; absorbs multi-cycle cache misses with a small FSM that holds a redirect arriving mid-miss until the miss completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction written into IF/ID on flush/reset (sll $0,$0,0)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
PCWrite  input  1  1 = PC may advance; 0 = hold (load-use stall)
if_id_Write  input  1  1 = IF/ID may load; 0 = hold
branch_taken  input  1  ID-resolved branch taken
branch_target  input  32  branch destination (byte address)
jump  input  1  ID-resolved j/jal/jr
jump_target  input  32  jump destination (byte address)
ICACHE_ren  output  1  read request
ICACHE_addr  output  30  word address = pc[31:2]
ICACHE_stall  input  1  1 = miss in progress, rdata invalid
ICACHE_rdata  input  32  instruction for ICACHE_addr, valid when ICACHE_stall=0
if_id_pc4  output  32  registered PC+4 of instruction in IF/ID
if_id_instr  output  32  registered instruction
if_id_valid  output  1  1 = IF/ID holds a real instruction
fetch_stall  output  1  = ICACHE_stall; freezes downstream stages
stall_cycles  output  32  saturating count of cycles with ICACHE_stall=1

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - pc=RESET_PC, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - state=RUN, pending_target=0, stall_cycles=0.
  - ICACHE_ren=0 while rst=1, then 1 in every state.
- Reset mid-miss discards any pending redirect; the first fetch after reset is from RESET_PC.
- ICACHE_addr is combinational from pc[31:2]. Response has zero extra latency: when ICACHE_stall=0, rdata is valid for the current address that cycle.
- Redirect:
  - redir = jump | branch_taken.
  - Target = jump_target if jump=1, else branch_target (jump has priority).
  - Targets are used as given; bits [1:0] are ignored by the address path.
- States:
  - RUN:
    - If ICACHE_stall=0 and redir: pc<=target; IF/ID flushed (instr=NOP_INSTR, valid=0, pc4 unchanged). Redirect overrides PCWrite=0 and if_id_Write=0.
    - Else if ICACHE_stall=0:
      - If PCWrite: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
      - If if_id_Write: if_id_instr<=rdata, if_id_pc4<=pc+4, if_id_valid<=1.
      - PCWrite and if_id_Write are applied independently.
    - If ICACHE_stall=1 and redir: pending_target<=target, go to MISS_REDIR.
    - If ICACHE_stall=1 and no redir: go to MISS.
    - Whenever ICACHE_stall=1: pc and IF/ID hold.
  - MISS:
    - pc and IF/ID hold.
    - redir while stalled: latch pending_target, go to MISS_REDIR.
    - ICACHE_stall falls (no redir that cycle): perform the RUN non-stall update that cycle, go to RUN.
    - ICACHE_stall falls with redir that cycle: apply the redirect as RUN does, go to RUN.
  - MISS_REDIR:
    - pc and IF/ID hold.
    - A newer redir overwrites pending_target (newest wins).
    - When ICACHE_stall falls: pc<=pending_target (or the live target if redir is asserted that cycle), IF/ID flushed, rdata discarded, go to RUN.
- stall_cycles increments on each cycle with ICACHE_stall=1, saturates at 32'hFFFF_FFFF, and clears only on rst.
- No state changes while rst=1 regardless of other inputs.

Test Plan:
1. Reset then free-run, no stalls, rdata=addr-dependent pattern -> pc sequence 0,4,8,12; if_id_pc4=4,8,12 one cycle behind; if_id_valid=1 from second cycle.
2. At pc=0x10, hold PCWrite=0 and if_id_Write=0 for 2 cycles -> pc stays 0x10; IF/ID holds instr fetched from 0x0C; then resumes with 0x10.
3. branch_taken=1, branch_target=0x100 with jump=1, jump_target=0x200 in the same cycle -> next pc=0x200, if_id_instr=0, if_id_valid=0.
4. ICACHE_stall high 5 cycles at pc=0x20; branch_taken=1 (target 0x80) in cycle 2, jump=1 (target 0x40) in cycle 4; stall drops -> pc=0x40, IF/ID flushed, stall_cycles=5.
5. rst asserted during MISS_REDIR -> pc=RESET_PC, state RUN, pending discarded, stall_cycles=0.
6. pc=0xFFFF_FFFC free-run -> pc wraps to 0x0000_0000, if_id_pc4=0x0000_0000.
